// File: rtl/df_pkg.sv
// rtl/df_pkg.sv - DF flop {d,f} codes and command generator FSM states
package df_pkg;

    localparam logic [1:0] DF_SET  = 2'b00;
    localparam logic [1:0] DF_HOLD = 2'b01;
    localparam logic [1:0] DF_RST  = 2'b10;
    localparam logic [1:0] DF_TGL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK
    } state_t;

endpackage

// File: rtl/df_fifo.sv
// rtl/df_fifo.sv - synchronous target FIFO with full/empty flags
module df_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic [WIDTH-1:0] in_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [WIDTH-1:0] out_tdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign in_tready  = (count != FULL_CNT);
    assign out_tvalid = (count != '0);
    assign push       = in_tvalid && in_tready;
    assign pop        = out_tready && out_tvalid;
    assign out_tdata  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_tdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/df_cmd_gen.sv
// rtl/df_cmd_gen.sv - steers a DF flop bank to queued targets and checks the result
module df_cmd_gen
    import df_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int DEPTH      = 4,
    parameter bit USE_TOGGLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] q_obs,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask,
    input  logic             err_clr
);

    state_t           state;
    state_t           state_n;
    logic             fifo_ready;
    logic             fifo_valid;
    logic             pop;
    logic             check;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] model;
    logic [WIDTH-1:0] code_d;
    logic [WIDTH-1:0] code_f;
    logic [WIDTH-1:0] mism;
    logic [1:0]       bit_code;

    df_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_tvalid (tgt_valid),
        .in_tready (fifo_ready),
        .in_tdata  (tgt_data),
        .out_tvalid(fifo_valid),
        .out_tready(pop),
        .out_tdata (head)
    );

    assign tgt_ready = rst_n && fifo_ready;
    assign busy      = (state != IDLE) || fifo_valid;
    assign mism      = check ? (q_obs ^ model) : '0;

    // Code is computed from the FIFO head against the tracked bank state.
    always_comb begin
        code_d   = '0;
        code_f   = '1;
        bit_code = DF_HOLD;
        for (int i = 0; i < WIDTH; i++) begin
            if (model[i] == head[i]) begin
                bit_code = DF_HOLD;
            end else if (USE_TOGGLE) begin
                bit_code = DF_TGL;
            end else begin
                bit_code = head[i] ? DF_SET : DF_RST;
            end
            {code_d[i], code_f[i]} = bit_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        check   = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_valid) begin
                    pop     = 1'b1;
                    state_n = DRIVE;
                end
            end
            DRIVE: begin
                state_n = CHECK;
            end
            CHECK: begin
                check = 1'b1;
                if (fifo_valid) begin
                    pop     = 1'b1;
                    state_n = DRIVE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // A new mismatch beats a simultaneous clear so no error is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d        <= '0;
            f        <= '1;
            tgt_q    <= '0;
            model    <= '1;
            done     <= 1'b0;
            err      <= 1'b0;
            err_mask <= '0;
        end else begin
            d <= pop ? code_d : '0;
            f <= pop ? code_f : '1;
            if (pop) begin
                tgt_q <= head;
            end
            if (state == DRIVE) begin
                model <= tgt_q;
            end
            done     <= check;
            err      <= (err && !err_clr) || (|mism);
            err_mask <= (err_mask & ~{WIDTH{err_clr}}) | mism;
        end
    end

endmodule

// File: tb/tb_df_cmd_gen.sv
// tb/tb_df_cmd_gen.sv - bench for df_cmd_gen with ideal DF bank models, both code styles
module tb_df_cmd_gen;

    localparam int DEPTH = 4;

    typedef struct {
        logic [1:0] tgt;
        int         a;
        int         drive;
        logic [3:0] c0;
        logic [3:0] c1;
    } ent_t;

    typedef struct {
        logic [1:0] tgt;
        logic [1:0] d0;
        logic [1:0] f0;
        logic [1:0] d1;
        logic [1:0] f1;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tgt_valid = 1'b0;
    logic [1:0] tgt_data = 2'b00;
    logic       err_clr = 1'b0;
    logic [1:0] stuck = 2'b00;

    logic       tgt_ready0, busy0, done0, err0;
    logic [1:0] d0, f0, q_obs0, err_mask0, bank0;
    logic       tgt_ready1, busy1, done1, err1;
    logic [1:0] d1, f1, q_obs1, err_mask1, bank1;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         last_drive = -100;
    logic [1:0] ref_model = 2'b11;
    logic       err_exp = 1'b0;
    logic [1:0] mask_exp = 2'b00;
    logic       exp_ready = 1'b1;
    ent_t       sched[$];

    always #5 clk = ~clk;

    assign q_obs0 = bank0 | stuck;
    assign q_obs1 = bank1 | stuck;

    df_cmd_gen #(.WIDTH(2), .DEPTH(DEPTH), .USE_TOGGLE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready0),
        .tgt_data(tgt_data), .d(d0), .f(f0), .q_obs(q_obs0), .busy(busy0),
        .done(done0), .err(err0), .err_mask(err_mask0), .err_clr(err_clr)
    );

    df_cmd_gen #(.WIDTH(2), .DEPTH(DEPTH), .USE_TOGGLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready1),
        .tgt_data(tgt_data), .d(d1), .f(f1), .q_obs(q_obs1), .busy(busy1),
        .done(done1), .err(err1), .err_mask(err_mask1), .err_clr(err_clr)
    );

    function automatic logic [1:0] bank_next(input logic [1:0] q, input logic [1:0] dd,
                                             input logic [1:0] ff);
        logic [1:0] r;
        r = q;
        for (int i = 0; i < 2; i++) begin
            case ({dd[i], ff[i]})
                2'b00:   r[i] = 1'b1;
                2'b01:   r[i] = q[i];
                2'b10:   r[i] = 1'b0;
                default: r[i] = ~q[i];
            endcase
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank0 <= 2'b11;
            bank1 <= 2'b11;
        end else begin
            bank0 <= bank_next(bank0, d0, f0);
            bank1 <= bank_next(bank1, d1, f1);
        end
    end

    function automatic logic [3:0] exp_code(input logic [1:0] m, input logic [1:0] t, input bit tog);
        logic [1:0] dd;
        logic [1:0] ff;
        dd = 2'b00;
        ff = 2'b11;
        for (int i = 0; i < 2; i++) begin
            if (m[i] != t[i]) begin
                if (tog) begin
                    dd[i] = 1'b1;
                    ff[i] = 1'b1;
                end else begin
                    dd[i] = ~t[i];
                    ff[i] = 1'b0;
                end
            end
        end
        return {dd, ff};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_outputs();
        logic [1:0] ed0, ef0, ed1, ef1, etgt;
        logic       edone, ebusy;
        int         occ;
        ed0 = 2'b00; ef0 = 2'b11; ed1 = 2'b00; ef1 = 2'b11;
        edone = 1'b0; ebusy = 1'b0; occ = 0; etgt = 2'b00;
        foreach (sched[i]) begin
            if (sched[i].drive == cyc) begin
                {ed0, ef0} = sched[i].c0;
                {ed1, ef1} = sched[i].c1;
            end
            if (sched[i].drive + 2 == cyc) begin
                edone = 1'b1;
                etgt  = sched[i].tgt;
            end
            if (sched[i].drive == cyc || sched[i].drive + 1 == cyc) ebusy = 1'b1;
            if (sched[i].drive > cyc) occ++;
        end
        if (occ > 0) ebusy = 1'b1;
        exp_ready = (occ < DEPTH);
        chk("d0", 8'(d0), 8'(ed0));          chk("f0", 8'(f0), 8'(ef0));
        chk("d1", 8'(d1), 8'(ed1));          chk("f1", 8'(f1), 8'(ef1));
        chk("ready0", 8'(tgt_ready0), 8'(exp_ready));
        chk("ready1", 8'(tgt_ready1), 8'(exp_ready));
        chk("done0", 8'(done0), 8'(edone));  chk("done1", 8'(done1), 8'(edone));
        chk("busy0", 8'(busy0), 8'(ebusy));  chk("busy1", 8'(busy1), 8'(ebusy));
        chk("err0", 8'(err0), 8'(err_exp));  chk("err1", 8'(err1), 8'(err_exp));
        chk("mask0", 8'(err_mask0), 8'(mask_exp));
        chk("mask1", 8'(err_mask1), 8'(mask_exp));
        if (edone) begin
            chk("bank0_order", 8'(bank0), 8'(etgt));
            chk("bank1_order", 8'(bank1), 8'(etgt));
        end
        while (sched.size() > 0 && sched[0].drive + 2 < cyc) void'(sched.pop_front());
    endtask

    task automatic cycle(input logic v, input logic [1:0] data, input logic clr, output logic acc);
        ent_t       e;
        logic [1:0] mism;
        tgt_valid = v;
        tgt_data  = data;
        err_clr   = clr;
        @(posedge clk);
        #1;
        cyc++;
        acc = v && exp_ready;
        if (acc) begin
            e.tgt   = data;
            e.a     = cyc;
            e.drive = (cyc + 1 > last_drive + 2) ? cyc + 1 : last_drive + 2;
            e.c0    = exp_code(ref_model, data, 1'b0);
            e.c1    = exp_code(ref_model, data, 1'b1);
            sched.push_back(e);
            ref_model  = data;
            last_drive = e.drive;
        end
        mism = 2'b00;
        foreach (sched[i]) begin
            if (sched[i].drive + 2 == cyc) mism = stuck & ~sched[i].tgt;
        end
        err_exp  = (err_exp && !clr) || (mism != 2'b00);
        mask_exp = (clr ? 2'b00 : mask_exp) | mism;
        check_outputs();
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 1'b0, acc);
    endtask

    task automatic pulse_reset();
        tgt_valid = 1'b0;
        err_clr   = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_d0", 8'(d0), 8'h0);          chk("rst_f0", 8'(f0), 8'h3);
        chk("rst_d1", 8'(d1), 8'h0);          chk("rst_f1", 8'(f1), 8'h3);
        chk("rst_ready0", 8'(tgt_ready0), 8'h0);
        chk("rst_busy0", 8'(busy0), 8'h0);    chk("rst_done0", 8'(done0), 8'h0);
        chk("rst_err0", 8'(err0), 8'h0);      chk("rst_mask0", 8'(err_mask0), 8'h0);
        sched.delete();
        ref_model  = 2'b11;
        err_exp    = 1'b0;
        mask_exp   = 2'b00;
        exp_ready  = 1'b1;
        last_drive = -100;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[9];
        logic       acc;
        logic       full_seen;
        int         ndone;
        int         idx;
        logic [1:0] words[8];

        tbl[0] = '{tgt: 2'b10, d0: 2'b01, f0: 2'b10, d1: 2'b01, f1: 2'b11};
        tbl[1] = '{tgt: 2'b00, d0: 2'b10, f0: 2'b01, d1: 2'b10, f1: 2'b11};
        tbl[2] = '{tgt: 2'b00, d0: 2'b00, f0: 2'b11, d1: 2'b00, f1: 2'b11};
        tbl[3] = '{tgt: 2'b01, d0: 2'b00, f0: 2'b10, d1: 2'b01, f1: 2'b11};
        tbl[4] = '{tgt: 2'b11, d0: 2'b00, f0: 2'b01, d1: 2'b10, f1: 2'b11};
        tbl[5] = '{tgt: 2'b00, d0: 2'b11, f0: 2'b00, d1: 2'b11, f1: 2'b11};
        tbl[6] = '{tgt: 2'b11, d0: 2'b00, f0: 2'b00, d1: 2'b11, f1: 2'b11};
        tbl[7] = '{tgt: 2'b00, d0: 2'b11, f0: 2'b00, d1: 2'b11, f1: 2'b11};
        tbl[8] = '{tgt: 2'b00, d0: 2'b00, f0: 2'b11, d1: 2'b00, f1: 2'b11};

        #13;
        chk("inrst_ready0", 8'(tgt_ready0), 8'h0);
        chk("inrst_ready1", 8'(tgt_ready1), 8'h0);
        chk("inrst_df0", 8'({d0, f0}), 8'h3);
        rst_n = 1'b1;
        idle(2);

        // Isolated pushes: code on the drive cycle, done three cycles after accept.
        for (int k = 0; k < 9; k++) begin
            cycle(1'b1, tbl[k].tgt, 1'b0, acc);
            chk("tbl_accept", 8'(acc), 8'h1);
            idle(1);
            chk("tbl_d0", 8'(d0), 8'(tbl[k].d0));  chk("tbl_f0", 8'(f0), 8'(tbl[k].f0));
            chk("tbl_d1", 8'(d1), 8'(tbl[k].d1));  chk("tbl_f1", 8'(f1), 8'(tbl[k].f1));
            idle(2);
            chk("tbl_done", 8'(done0), 8'h1);
            chk("tbl_qobs", 8'(q_obs0), 8'(tbl[k].tgt));
            chk("tbl_err", 8'(err0 | err1), 8'h0);
            idle(1);
        end

        // Back-to-back pushes overrun the FIFO.
        for (int i = 0; i < 8; i++) words[i] = 2'($urandom_range(0, 3));
        idx = 0; ndone = 0; full_seen = 1'b0;
        for (int k = 0; k < 40 && idx < 8; k++) begin
            cycle(1'b1, words[idx], 1'b0, acc);
            if (acc) idx++;
            if (!tgt_ready0) full_seen = 1'b1;
            if (done0) ndone++;
        end
        chk("b2b_pushed", 8'(idx), 8'd8);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 2'b00, 1'b0, acc);
            if (done0) ndone++;
        end
        chk("b2b_full_seen", 8'(full_seen), 8'h1);
        chk("b2b_done_count", 8'(ndone), 8'd8);

        // Stuck-at-1 on bit 1, then clear, then clear colliding with a new mismatch.
        stuck = 2'b10;
        cycle(1'b1, 2'b00, 1'b0, acc);
        idle(3);
        chk("stuck_err", 8'(err0), 8'h1);
        chk("stuck_mask", 8'(err_mask0), 8'h2);
        cycle(1'b0, 2'b00, 1'b1, acc);
        chk("clr_err", 8'(err0), 8'h0);
        chk("clr_mask", 8'(err_mask1), 8'h0);
        cycle(1'b1, 2'b00, 1'b0, acc);
        idle(2);
        cycle(1'b0, 2'b00, 1'b1, acc);
        chk("clr_vs_set_err", 8'(err0), 8'h1);
        chk("clr_vs_set_mask", 8'(err_mask0), 8'h2);
        cycle(1'b0, 2'b00, 1'b1, acc);
        stuck = 2'b00;
        idle(1);

        // Reset during DRIVE with more words queued.
        cycle(1'b1, 2'b11, 1'b0, acc);
        cycle(1'b1, 2'b10, 1'b0, acc);
        chk("pre_rst_drive_d0", 8'(d0), 8'h0);
        chk("pre_rst_drive_f0", 8'(f0), 8'h0);
        pulse_reset();
        idle(1);
        chk("post_rst_busy", 8'(busy0), 8'h0);
        chk("post_rst_ready", 8'(tgt_ready0), 8'h1);
        cycle(1'b1, 2'b01, 1'b0, acc);
        idle(1);
        chk("post_rst_d0", 8'(d0), 8'h2);  chk("post_rst_f0", 8'(f0), 8'h1);
        chk("post_rst_d1", 8'(d1), 8'h2);  chk("post_rst_f1", 8'(f1), 8'h3);
        idle(4);

        // Random traffic against the schedule model.
        for (int k = 0; k < 300; k++) begin
            if (k == 150) stuck = 2'($urandom_range(0, 3));
            cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), acc);
        end
        stuck = 2'b00;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
